serial_nibble_adder: RTL and testbench

//   Multi-cycle wide adder that adds two NIBBLES*4-bit operands one 4-bit

---
 rtl/serial_nibble_adder.sv | 104 ++++++++++
 tb/tb_serial_nibble_adder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/serial_nibble_adder.sv
// Multi-cycle adder: one 4-bit slice per clock, LS nibble first, carry
// registered between slices. valid/ready operand capture, one-cycle done pulse.
module serial_nibble_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   done,
  output logic                   busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_idx;
  logic            r_carry;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;
  logic            r_cout;
  logic [4:0]      w_slice;
  logic            w_last;
  logic            w_accept;

  function automatic logic [3:0] get_nib(input logic [W-1:0] v, input logic [IW-1:0] i);
    logic [3:0] r;
    r = 4'h0;
    for (int n = 0; n < NIBBLES; n++)
      if (i == IW'(n)) r = v[4*n +: 4];
    return r;
  endfunction

  function automatic logic [4:0] add_slice(input logic [3:0] x, input logic [3:0] y,
                                           input logic c);
    return {1'b0, x} + {1'b0, y} + {4'b0000, c};
  endfunction

  assign w_slice  = add_slice(get_nib(r_a, r_idx), get_nib(r_b, r_idx), r_carry);
  assign w_last   = (r_idx == LAST);
  assign w_accept = start_valid && (r_state == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start_valid) w_next = S_RUN;
      S_RUN:   if (w_last)      w_next = S_DONE;
      S_DONE:                   w_next = S_IDLE;
      default:                  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    start_ready = (r_state == S_IDLE);
    busy        = (r_state != S_IDLE);
    done        = (r_state == S_DONE);
  end

  // Datapath: operands latched at accept; sum/cout hold until a slice rewrites them
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_idx   <= '0;
      r_carry <= 1'b0;
    end else if (r_state == S_RUN) begin
      for (int n = 0; n < NIBBLES; n++)
        if (r_idx == IW'(n)) r_sum[4*n +: 4] <= w_slice[3:0];
      r_carry <= w_slice[4];
      if (w_last) begin
        r_cout <= w_slice[4];
        r_idx  <= '0;
      end else begin
        r_idx  <= r_idx + 1'b1;
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Scoreboard bench for serial_nibble_adder: a 4-nibble instance for the main
// scenarios and a 1-nibble instance for the exhaustive 4-bit sweep.
module tb_serial_nibble_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        sv4, sr4, done4, busy4, cout4;
  logic [15:0] a4, b4, sum4;
  logic        sv1, sr1, done1, busy1, cout1;
  logic [3:0]  a1, b1, sum1;

  logic [16:0] q4[$];
  logic [4:0]  q1[$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_nibble_adder #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst(rst), .start_valid(sv4), .start_ready(sr4), .a(a4), .b(b4),
    .sum(sum4), .cout(cout4), .done(done4), .busy(busy4));

  serial_nibble_adder #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .start_valid(sv1), .start_ready(sr1), .a(a1), .b(b1),
    .sum(sum1), .cout(cout1), .done(done1), .busy(busy1));

  // Drive one accept on dut4 and push the reference sum
  task automatic start4(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    sv4 = 1'b1; a4 = a; b4 = b;
    q4.push_back({1'b0, a} + {1'b0, b});
    @(posedge clk);
    #1 sv4 = 1'b0;
  endtask

  // Negedges after the accept until done (0 = timeout)
  task automatic wait4(output int lat, output logic [16:0] got);
    bit seen = 0;
    int i = 0;
    lat = 0; got = '0;
    while (!seen && i < 20) begin
      @(negedge clk);
      i++;
      if (done4) begin seen = 1; lat = i; got = {cout4, sum4}; end
    end
  endtask

  task automatic start1(input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    sv1 = 1'b1; a1 = a; b1 = b;
    q1.push_back({1'b0, a} + {1'b0, b});
    @(posedge clk);
    #1 sv1 = 1'b0;
  endtask

  task automatic wait1(output int lat, output logic [4:0] got);
    bit seen = 0;
    int i = 0;
    lat = 0; got = '0;
    while (!seen && i < 10) begin
      @(negedge clk);
      i++;
      if (done1) begin seen = 1; lat = i; got = {cout1, sum1}; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (sum4 !== 16'h0) begin n_err++; $display("FAIL reset_sum got=%h exp=0000", sum4); end
    n_cmp++; if (cout4 !== 1'b0) begin n_err++; $display("FAIL reset_cout got=%b exp=0", cout4); end
    n_cmp++; if (done4 !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done4); end
    n_cmp++; if (busy4 !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy4); end
    n_cmp++; if (sr4 !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", sr4); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [15:0] av[3] = '{16'h0000, 16'h1234, 16'hFFFF};
    logic [15:0] bv[3] = '{16'h0000, 16'h4321, 16'h0001};
    logic [16:0] got, exp;
    int lat;
    for (int t = 0; t < 3; t++) begin
      start4(av[t], bv[t]);
      n_cmp++; if (busy4 !== 1'b1) begin n_err++; $display("FAIL basic_busy t=%0d got=%b exp=1", t, busy4); end
      wait4(lat, got);
      exp = q4.pop_front();
      n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL basic_latency t=%0d got=%0d exp=5", t, lat); end
      n_cmp++; if (got !== exp) begin n_err++; $display("FAIL basic_result t=%0d got=%h exp=%h", t, got, exp); end
      n_cmp++; if (sr4 !== 1'b0) begin n_err++; $display("FAIL done_ready t=%0d got=%b exp=0", t, sr4); end
      @(negedge clk);
      n_cmp++; if (done4 !== 1'b0) begin n_err++; $display("FAIL done_pulse_width t=%0d got=%b exp=0", t, done4); end
      n_cmp++; if ({cout4, sum4} !== exp) begin n_err++; $display("FAIL hold_after_done t=%0d got=%h exp=%h", t, {cout4, sum4}, exp); end
      n_cmp++; if (sr4 !== 1'b1 || busy4 !== 1'b0) begin n_err++; $display("FAIL idle_after_done t=%0d ready=%b busy=%b exp=1/0", t, sr4, busy4); end
    end
  endtask

  task automatic test_carry_clear;
    logic [16:0] got, exp;
    int lat;
    start4(16'h8000, 16'h8000);
    wait4(lat, got);
    exp = q4.pop_front();
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL carry_msb got=%h exp=%h", got, exp); end
    start4(16'h0000, 16'h0000);
    wait4(lat, got);
    exp = q4.pop_front();
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL carry_cleared got=%h exp=%h", got, exp); end
  endtask

  task automatic test_busy_ignore;
    logic [16:0] got, exp;
    int pulses = 0;
    start4(16'h1111, 16'h2222);
    exp = q4.pop_front();
    got = '0;
    for (int i = 1; i <= 12; i++) begin
      if (i <= 3) begin
        sv4 = 1'b1; a4 = 16'hFFFF; b4 = 16'hFFFF;
        n_cmp++; if (sr4 !== 1'b0) begin n_err++; $display("FAIL busy_ready i=%0d got=%b exp=0", i, sr4); end
      end else begin
        sv4 = 1'b0;
      end
      @(negedge clk);
      if (done4) begin pulses++; got = {cout4, sum4}; end
    end
    sv4 = 1'b0;
    n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL busy_done_count got=%0d exp=1", pulses); end
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL busy_result got=%h exp=%h", got, exp); end
  endtask

  task automatic test_reset_mid;
    logic [16:0] got, exp;
    int lat;
    int pulses = 0;
    start4(16'hABCD, 16'h1111);
    void'(q4.pop_back());
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (busy4 !== 1'b0 || sr4 !== 1'b1) begin n_err++; $display("FAIL midreset_state busy=%b ready=%b exp=0/1", busy4, sr4); end
    n_cmp++; if ({cout4, sum4} !== 17'h0) begin n_err++; $display("FAIL midreset_result got=%h exp=00000", {cout4, sum4}); end
    for (int i = 0; i < 8; i++) begin
      if (done4) pulses++;
      @(negedge clk);
    end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL midreset_no_done got=%0d exp=0", pulses); end
    start4(16'h0F0F, 16'h00F1);
    wait4(lat, got);
    exp = q4.pop_front();
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL midreset_fresh got=%h exp=%h", got, exp); end
  endtask

  task automatic test_nibble1;
    logic [4:0] got, exp;
    int lat;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        start1(4'(i), 4'(j));
        wait1(lat, got);
        exp = q1.pop_front();
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL n1_latency %0d+%0d got=%0d exp=2", i, j, lat); end
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL n1_result %0d+%0d got=%h exp=%h", i, j, got, exp); end
      end
    end
  endtask

  task automatic test_random;
    logic [16:0] got, exp;
    int lat;
    for (int t = 0; t < 25; t++) begin
      start4(16'($urandom), 16'($urandom));
      wait4(lat, got);
      exp = q4.pop_front();
      n_cmp++; if (got !== exp || lat !== 5) begin n_err++; $display("FAIL random t=%0d got=%h lat=%0d exp=%h lat=5", t, got, lat, exp); end
    end
  endtask

  initial begin
    rst = 1'b1;
    sv4 = 1'b0; a4 = '0; b4 = '0;
    sv1 = 1'b0; a1 = '0; b1 = '0;
    test_reset;
    test_basic;
    test_carry_clear;
    test_busy_ignore;
    test_reset_mid;
    test_nibble1;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
